cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder built from 4-bit lookahead groups, with a valid/ready handshake on both sides and status flags. It generalises the 4-bit combinational CLA to WIDTH bits by cutting the group carry chain into registered stages, and it serves as the ALU adder path of the pipelined CPU cores.

---
 rtl/cla_pkg.sv | 33 +++
 rtl/cla_group4.sv | 32 +++
 rtl/cla_pipe_adder.sv | 170 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// per-stage control register layout, stage field widths and the parameter
// legality check used at elaboration.
package cla_pkg;

  // Bits per lookahead group.
  localparam int CLA_GRP = 4;

  // Control part of every stage register: occupancy and the carry leaving
  // the groups this stage has already resolved.
  typedef struct packed {
    logic valid;
    logic carry;
  } cla_ctl_t;

  // WIDTH must be a multiple of the group width, at least 8, and GPS must
  // split the groups evenly into stages.
  function automatic bit cla_cfg_ok(input int width, input int gps);
    return (width >= 8) && (width % CLA_GRP == 0) && (gps >= 1) &&
           ((width / CLA_GRP) % gps == 0);
  endfunction

  // Sum bits resolved once stage `stage` has run.
  function automatic int cla_sum_w(input int gps, input int stage);
    return (stage + 1) * gps * CLA_GRP;
  endfunction

  // Operand bits still waiting for later stages after stage `stage`.
  function automatic int cla_fwd_w(input int width, input int gps, input int stage);
    return width - (stage + 1) * gps * CLA_GRP;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: all internal carries and the
// group carry-out are expanded directly from generate/propagate terms.
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GRP-1:0] x,
  input  logic [CLA_GRP-1:0] y,
  input  logic               cin,
  output logic [CLA_GRP-1:0] s,
  output logic               cout
);

  logic [CLA_GRP-1:0] p;
  logic [CLA_GRP-1:0] g;
  logic [CLA_GRP-1:0] c;

  // Lookahead expansion of the carries over the four bits.
  always_comb begin
    p    = x | y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    // P&~G is the half-sum a^b for each bit.
    s    = (p & ~g) ^ c;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder with elastic valid/ready flow
// control. Each stage resolves GPS 4-bit groups, rippling the group carry
// inside the stage; stage registers carry the partial sum, the operand bits
// not yet consumed and the carry into the next stage.
// Optional feature macro: CLA_SUB_EN adds the sub port (a - b when sub=1).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG     = WIDTH / CLA_GRP;
  localparam int STAGES = NG / GPS;
  localparam int SW     = GPS * CLA_GRP;

  if (!cla_cfg_ok(WIDTH, GPS)) begin : g_cfg_bad
    $error("cla_pipe_adder: WIDTH must be a multiple of 4, >= 8, and GPS must divide WIDTH/4");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] adv_vec;

  // Operand conditioning at the pipeline entry; subtraction is folded into
  // the data here so nothing downstream needs to know about it.
  always_comb begin
    b_eff = b;
    c_eff = cin;
`ifdef CLA_SUB_EN
    if (sub) begin
      b_eff = ~b;
      c_eff = 1'b1;
    end
`endif
  end

  // Elastic advance: a stage loads when it is empty or its content moves on.
  always_comb begin
    adv_vec = '0;
    adv_vec[STAGES-1] = ~valid_vec[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_vec[k] = ~valid_vec[k] | adv_vec[k+1];
    end
  end

  assign in_ready = adv_vec[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    localparam int UW = WIDTH - gi * SW;     // operand bits entering this stage
    localparam int DW = cla_sum_w(GPS, gi);  // sum bits leaving this stage

    logic [UW-1:0] sa;
    logic [UW-1:0] sb;
    logic          sc;
    logic          sv;
    logic [SW-1:0] gs;
    logic [DW-1:0] ns;
    logic          co_last;
    cla_ctl_t      ctl_reg;
    logic [DW-1:0] s_reg;

    if (gi == 0) begin : g_src0
      assign sa = a;
      assign sb = b_eff;
      assign sc = c_eff;
      assign sv = in_valid;
      assign ns = gs;
    end else begin : g_srcn
      assign sa = stg[gi-1].g_fwd.a_reg;
      assign sb = stg[gi-1].g_fwd.b_reg;
      assign sc = stg[gi-1].ctl_reg.carry;
      assign sv = stg[gi-1].ctl_reg.valid;
      assign ns = {gs, stg[gi-1].s_reg};
    end

    // Group carries ripple through the GPS groups owned by this stage.
    for (genvar gj = 0; gj < GPS; gj++) begin : grp
      logic ci;
      logic co;
      if (gj == 0) begin : g_c0
        assign ci = sc;
      end else begin : g_cn
        assign ci = grp[gj-1].co;
      end
      cla_group4 u_grp (
        .x    (sa[gj*CLA_GRP +: CLA_GRP]),
        .y    (sb[gj*CLA_GRP +: CLA_GRP]),
        .cin  (ci),
        .s    (gs[gj*CLA_GRP +: CLA_GRP]),
        .cout (co)
      );
    end

    assign co_last       = grp[GPS-1].co;
    assign valid_vec[gi] = ctl_reg.valid;

    // Stage register: occupancy, carry and partial sum, held under stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_reg <= '0;
        s_reg   <= '0;
      end else if (adv_vec[gi]) begin
        ctl_reg.valid <= sv;
        ctl_reg.carry <= co_last;
        s_reg         <= ns;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      localparam int FW = cla_fwd_w(WIDTH, GPS, gi);
      logic [FW-1:0] a_reg;
      logic [FW-1:0] b_reg;

      // Upper operand bits travel alongside the partial sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv_vec[gi]) begin
          a_reg <= sa[UW-1:SW];
          b_reg <= sb[UW-1:SW];
        end
      end
    end else begin : g_last
      logic msbc_n;
      logic msbc_reg;
      logic zero_reg;

      // Carry into the MSB recovered from its sum bit and operand bits.
      assign msbc_n = gs[SW-1] ^ sa[UW-1] ^ sb[UW-1];

      // Flags that only make sense once the whole sum is known.
      always_ff @(posedge clk) begin
        if (rst) begin
          msbc_reg <= 1'b0;
          zero_reg <= 1'b0;
        end else if (adv_vec[gi]) begin
          msbc_reg <= msbc_n;
          zero_reg <= ~|ns;
        end
      end

      assign out_valid = ctl_reg.valid;
      assign sum       = s_reg;
      assign cout      = ctl_reg.carry;
      assign ovf       = msbc_reg ^ ctl_reg.carry;
      assign zero      = zero_reg;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=16, GPS=1 (four stages).
// Subtraction cases are compiled in when CLA_SUB_EN is defined.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_drv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  res_t q[$];

  cla_pipe_adder #(.WIDTH(W), .GPS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic cur_sub();
`ifdef CLA_SUB_EN
    return sub_drv;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain arithmetic and sign-rule overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   t;
    res_t         r;
    yy  = sb ? ~y : y;
    cc  = sb ? 1'b1 : ci;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    r.z = (r.s == '0);
    return r;
  endfunction

  // One clock: sample handshake at negedge, log accepted inputs, return
  // the observed output, then step past the rising edge.
  task automatic step(output bit acc, output bit drn, output bit vld,
                      output bit rdy, output res_t got);
    @(negedge clk);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    drn = (out_valid === 1'b1) && (out_ready === 1'b1);
    vld = (out_valid === 1'b1);
    rdy = (in_ready === 1'b1);
    got = {sum, cout, ovf, zero};
    if (acc) q.push_back(model(a, b, cin, cur_sub()));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); end
    $display("reset: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci, input logic sb, input logic [W-1:0] es,
                              input logic ec, input logic eo, input logic ez);
    bit acc, drn, vld, rdy;
    res_t got, e;
    int lat;
    out_ready = 1'b1; a = x; b = y; cin = ci; sub_drv = sb; in_valid = 1'b1;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      step(acc, drn, vld, rdy, got);
      if (k == 0) begin
        in_valid = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL %s_accept got %b want 1", name, acc); end
      end
      if (drn) begin
        lat = k;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL %s_unexpected got %h want none", name, got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin errors++; $display("FAIL %s_scoreboard got %h want %h", name, got, e); end
        end
        checks++;
        if (got !== {es, ec, eo, ez}) begin
          errors++; $display("FAIL %s_value got %h want %h", name, got, {es, ec, eo, ez});
        end
        $display("%s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b lat=%0d",
                 name, x, y, ci, sb, got.s, got.c, got.o, got.z, lat);
      end
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
    sub_drv = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit acc, drn, vld, rdy;
    res_t got, e;
    int n_in, n_out, first, last;
    n_in = 0; n_out = 0; first = -1; last = -1;
    out_ready = 1'b1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    for (int k = 0; k < 40 && n_out < 8; k++) begin
      step(acc, drn, vld, rdy, got);
      if (acc) begin
        n_in++;
        if (n_in < 8) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
        else in_valid = 1'b0;
      end
      if (drn) begin
        if (first < 0) first = k;
        last = k;
        n_out++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got %h want none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin errors++; $display("FAIL b2b_result got %h want %h", got, e); end
          $display("b2b[%0d]: sum=%h cout=%b ovf=%b zero=%b", n_out - 1, got.s, got.c, got.o, got.z);
        end
      end
    end
    checks++;
    if (n_out != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n_out); end
    checks++;
    if (last - first != 7) begin errors++; $display("FAIL b2b_consecutive got %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    bit acc, drn, vld, rdy;
    res_t got, e, held;
    int n_in, n_out;
    n_in = 0; n_out = 0; held = '0;
    out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(acc, drn, vld, rdy, got);
      if (acc) begin n_in++; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      if (k == 4) held = got;
      if (k == 5) begin
        checks++;
        if (!vld) begin errors++; $display("FAIL bp_out_valid got %b want 1", vld); end
        checks++;
        if (got !== held) begin errors++; $display("FAIL bp_held_stable got %h want %h", got, held); end
        checks++;
        if (rdy) begin errors++; $display("FAIL bp_in_ready got %b want 0", rdy); end
      end
    end
    checks++;
    if (n_in != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", n_in); end
    $display("backpressure: accepted %0d while stalled, held=%h", n_in, held);
    out_ready = 1'b1;
    for (int k = 0; k < 60 && n_out < 10; k++) begin
      step(acc, drn, vld, rdy, got);
      if (acc) begin
        n_in++;
        if (n_in < 10) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
        else in_valid = 1'b0;
      end
      if (drn) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_unexpected got %h want none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin errors++; $display("FAIL bp_result got %h want %h", got, e); end
          $display("bp[%0d]: sum=%h cout=%b ovf=%b zero=%b", n_out - 1, got.s, got.c, got.o, got.z);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out != 10 || n_in != 10) begin
      errors++; $display("FAIL bp_count got in=%0d out=%0d want 10/10", n_in, n_out);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    bit acc, drn, vld, rdy;
    res_t got;
    int n_in, n_vld;
    n_in = 0; n_vld = 0;
    out_ready = 1'b1;
    a = W'($urandom); b = W'($urandom); cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10 && n_in < 3; k++) begin
      step(acc, drn, vld, rdy, got);
      if (acc) begin n_in++; a = W'($urandom); b = W'($urandom); end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step(acc, drn, vld, rdy, got);
    rst = 1'b0;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      step(acc, drn, vld, rdy, got);
      if (vld) n_vld++;
      if (k == 0) begin
        checks++;
        if (got.s !== '0) begin errors++; $display("FAIL rstmid_sum got %h want 0000", got.s); end
      end
    end
    checks++;
    if (n_vld != 0) begin errors++; $display("FAIL rstmid_ghosts got %0d want 0", n_vld); end
    $display("reset_mid: %0d in flight discarded, %0d outputs after reset", n_in, n_vld);
  endtask

  initial begin
    test_reset();
    test_latency("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    test_latency("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    test_latency("cin",  16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_latency("post_rst", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
`ifdef CLA_SUB_EN
    test_latency("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    test_latency("sub_pos", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
